// File: rtl/alarm_sched.sv
// alarm_sched: day/hour/minute timekeeper driven by a 1 Hz tick, with a
// weekday alarm and a ringing / snoozed / idle state machine.
// Strobe semantics: tick, set_time, set_alarm, snooze and stop are sampled
// for exactly one cycle, on the clock edge where they are high. arm is a level.
module alarm_sched #(
    parameter int TICKS_PER_MIN      = 60,
    parameter int SNOOZE_MIN         = 9,
    parameter int MAX_SNOOZE         = 3,
    parameter int RING_MIN           = 5,
    parameter logic [6:0] DEFAULT_DAYS = 7'b0111110,
    localparam int SNZW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            set_time,
    input  logic [2:0]      set_day,
    input  logic [4:0]      set_hr,
    input  logic [5:0]      set_min,
    input  logic            set_alarm,
    input  logic [4:0]      alm_hr,
    input  logic [5:0]      alm_min,
    input  logic [6:0]      alm_days,
    input  logic            arm,
    input  logic            snooze,
    input  logic            stop,
    output logic            alrm,
    output logic [2:0]      cur_day,
    output logic [4:0]      cur_hr,
    output logic [5:0]      cur_min,
    output logic [1:0]      state,
    output logic [SNZW-1:0] snooze_cnt
);

    localparam int SECW = $clog2(TICKS_PER_MIN);
    localparam int TMAX = (SNOOZE_MIN > RING_MIN) ? SNOOZE_MIN : RING_MIN;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [SECW-1:0] SEC_LAST  = SECW'(TICKS_PER_MIN - 1);
    localparam logic [TW-1:0]   SNZ_LOAD  = TW'(SNOOZE_MIN);
    localparam logic [TW-1:0]   RING_LAST = TW'(RING_MIN - 1);
    localparam logic [SNZW-1:0] SNZ_MAX   = SNZW'(MAX_SNOOZE);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RING = 2'b01;
    localparam logic [1:0] S_SNZ  = 2'b10;

    logic [SECW-1:0] r_sec;
    logic [2:0]      r_day;
    logic [4:0]      r_hr;
    logic [5:0]      r_min;
    logic            r_min_upd;
    logic [4:0]      r_alm_hr;
    logic [5:0]      r_alm_min;
    logic [6:0]      r_alm_days;
    logic [1:0]      r_state;
    logic            r_alrm;
    logic [TW-1:0]   r_ring_cnt;
    logic [TW-1:0]   r_snz_cnt;
    logic [SNZW-1:0] r_snooze_cnt;

    logic            w_ld_time;
    logic            w_ld_alm;
    logic            w_tick;
    logic            w_sec_wrap;
    logic            w_match;
    logic            w_snz_ok;
    logic [1:0]      w_next_state;
    logic            w_alrm_d;

    // Range-checked loads; an accepted set_time swallows a coincident tick.
    assign w_ld_time  = set_time && (set_day <= 3'd6) && (set_hr <= 5'd23) && (set_min <= 6'd59);
    assign w_ld_alm   = set_alarm && (alm_hr <= 5'd23) && (alm_min <= 6'd59);
    assign w_tick     = tick && !w_ld_time;
    assign w_sec_wrap = w_tick && (r_sec == SEC_LAST);
    assign w_match    = r_min_upd && arm && (r_hr == r_alm_hr) && (r_min == r_alm_min)
                        && r_alm_days[r_day];
    assign w_snz_ok   = (r_state == S_RING) && snooze && (r_snooze_cnt < SNZ_MAX);

    // Seconds / minute / hour / weekday counters and the one-cycle minute pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec     <= '0;
            r_day     <= 3'd0;
            r_hr      <= 5'd0;
            r_min     <= 6'd0;
            r_min_upd <= 1'b0;
        end else begin
            r_min_upd <= w_sec_wrap;
            if (w_ld_time) begin
                r_sec <= '0;
                r_day <= set_day;
                r_hr  <= set_hr;
                r_min <= set_min;
            end else if (w_sec_wrap) begin
                r_sec <= '0;
                if (r_min == 6'd59) begin
                    r_min <= 6'd0;
                    if (r_hr == 5'd23) begin
                        r_hr  <= 5'd0;
                        r_day <= (r_day == 3'd6) ? 3'd0 : r_day + 3'd1;
                    end else begin
                        r_hr <= r_hr + 5'd1;
                    end
                end else begin
                    r_min <= r_min + 6'd1;
                end
            end else if (w_tick) begin
                r_sec <= r_sec + SECW'(1);
            end
        end
    end

    // Programmed alarm time and day mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alm_hr   <= 5'd0;
            r_alm_min  <= 6'd0;
            r_alm_days <= DEFAULT_DAYS;
        end else if (w_ld_alm) begin
            r_alm_hr   <= alm_hr;
            r_alm_min  <= alm_min;
            r_alm_days <= alm_days;
        end
    end

    // State register; alrm is registered alongside it so both change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_alrm  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_alrm  <= w_alrm_d;
        end
    end

    // Next state: set_alarm > arm low > stop > snooze > minute timers.
    always_comb begin
        w_next_state = r_state;
        if (w_ld_alm || !arm) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_match) w_next_state = S_RING;
                S_RING: begin
                    if (stop)                                      w_next_state = S_IDLE;
                    else if (w_snz_ok)                             w_next_state = S_SNZ;
                    else if (r_min_upd && (r_ring_cnt == RING_LAST)) w_next_state = S_IDLE;
                end
                S_SNZ: begin
                    if (stop)                                        w_next_state = S_IDLE;
                    else if (r_min_upd && (r_snz_cnt == TW'(1)))     w_next_state = S_RING;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Output decode: buzzer on whenever the machine is about to be RINGING.
    always_comb begin
        w_alrm_d = (w_next_state == S_RING);
    end

    // Ring timeout, snooze countdown and per-event snooze usage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ring_cnt   <= '0;
            r_snz_cnt    <= '0;
            r_snooze_cnt <= '0;
        end else begin
            if ((w_next_state == S_RING) && (r_state != S_RING))
                r_ring_cnt <= '0;
            else if ((r_state == S_RING) && (w_next_state == S_RING) && r_min_upd)
                r_ring_cnt <= r_ring_cnt + TW'(1);

            if ((r_state == S_RING) && (w_next_state == S_SNZ))
                r_snz_cnt <= SNZ_LOAD;
            else if ((r_state == S_SNZ) && r_min_upd && (r_snz_cnt != '0))
                r_snz_cnt <= r_snz_cnt - TW'(1);

            if (w_next_state == S_IDLE)
                r_snooze_cnt <= '0;
            else if ((r_state == S_RING) && (w_next_state == S_SNZ))
                r_snooze_cnt <= r_snooze_cnt + SNZW'(1);
        end
    end

    assign alrm       = r_alrm;
    assign cur_day    = r_day;
    assign cur_hr     = r_hr;
    assign cur_min    = r_min;
    assign state      = r_state;
    assign snooze_cnt = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_sched.sv
// Bench for alarm_sched: table of time loads, hand-written ring/snooze/timeout
// sequences, async reset, then random traffic against a minute-of-week model.
module tb_alarm_sched;

    localparam int TPM  = 2;
    localparam int SNZ  = 2;
    localparam int MAXS = 1;
    localparam int RING = 2;

    logic       clk;
    logic       rst_n;
    logic       tick, set_time, set_alarm, arm, snooze, stop;
    logic [2:0] set_day;
    logic [4:0] set_hr, alm_hr;
    logic [5:0] set_min, alm_min;
    logic [6:0] alm_days;
    logic       alrm;
    logic [2:0] cur_day;
    logic [4:0] cur_hr;
    logic [5:0] cur_min;
    logic [1:0] state;
    logic [0:0] snooze_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [17:0] exp_q[$];

    // model state: minute of week, seconds, minute pulse, alarm, FSM
    int         m_t, m_sec, m_ah, m_am, m_st, m_used, m_ring, m_left;
    bit         m_upd;
    logic [6:0] m_days;

    alarm_sched #(
        .TICKS_PER_MIN(TPM), .SNOOZE_MIN(SNZ), .MAX_SNOOZE(MAXS), .RING_MIN(RING),
        .DEFAULT_DAYS(7'b0111110)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .set_time(set_time),
        .set_day(set_day), .set_hr(set_hr), .set_min(set_min),
        .set_alarm(set_alarm), .alm_hr(alm_hr), .alm_min(alm_min), .alm_days(alm_days),
        .arm(arm), .snooze(snooze), .stop(stop), .alrm(alrm),
        .cur_day(cur_day), .cur_hr(cur_hr), .cur_min(cur_min),
        .state(state), .snooze_cnt(snooze_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_t = 0; m_sec = 0; m_upd = 0;
        m_ah = 0; m_am = 0; m_days = 7'b0111110;
        m_st = 0; m_used = 0; m_ring = 0; m_left = 0;
    endfunction

    // One clock edge of behaviour, using the inputs currently applied.
    task automatic model_step();
        int d, h, mi;
        bit match, a_ok, t_ok;
        d = m_t / 1440; h = (m_t / 60) % 24; mi = m_t % 60;
        match = m_upd && arm && (h == m_ah) && (mi == m_am) && m_days[d];
        a_ok  = set_alarm && (alm_hr < 24) && (alm_min < 60);
        t_ok  = set_time && (set_day < 7) && (set_hr < 24) && (set_min < 60);
        if (a_ok || !arm) begin
            m_st = 0; m_used = 0;
        end else begin
            case (m_st)
                0: if (match) begin m_st = 1; m_ring = 0; end
                1: begin
                    if (stop) begin m_st = 0; m_used = 0; end
                    else if (snooze && m_used < MAXS) begin m_st = 2; m_used++; m_left = SNZ; end
                    else if (m_upd) begin
                        m_ring++;
                        if (m_ring == RING) begin m_st = 0; m_used = 0; end
                    end
                end
                default: begin
                    if (stop) begin m_st = 0; m_used = 0; end
                    else if (m_upd) begin
                        m_left--;
                        if (m_left == 0) begin m_st = 1; m_ring = 0; end
                    end
                end
            endcase
        end
        if (a_ok) begin m_ah = alm_hr; m_am = alm_min; m_days = alm_days; end
        if (t_ok) begin
            m_t = set_day * 1440 + set_hr * 60 + set_min; m_sec = 0; m_upd = 0;
        end else if (tick) begin
            if (m_sec == TPM - 1) begin m_sec = 0; m_t = (m_t + 1) % 10080; m_upd = 1; end
            else begin m_sec++; m_upd = 0; end
        end else begin
            m_upd = 0;
        end
        d = m_t / 1440; h = (m_t / 60) % 24; mi = m_t % 60;
        exp_q.push_back({(m_st == 1), 3'(d), 5'(h), 6'(mi), 2'(m_st), 1'(m_used)});
    endtask

    // One cycle: edge, model, scoreboard compare, then strobes drop.
    task automatic clk_step();
        logic [17:0] exp_v, act_v;
        @(posedge clk);
        model_step();
        #1;
        exp_v = exp_q.pop_front();
        act_v = {alrm, cur_day, cur_hr, cur_min, state, snooze_cnt};
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, act_v, exp_v);
        end
        tick = 0; set_time = 0; set_alarm = 0; snooze = 0; stop = 0;
    endtask

    task automatic do_set_time(input int d, input int h, input int m, input bit tk);
        set_time = 1; set_day = 3'(d); set_hr = 5'(h); set_min = 6'(m); tick = tk;
        clk_step();
    endtask

    task automatic do_set_alarm(input int h, input int m, input logic [6:0] days);
        set_alarm = 1; alm_hr = 5'(h); alm_min = 6'(m); alm_days = days;
        clk_step();
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin tick = 1; clk_step(); end
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    // Bring the alarm to RINGING from d/hh:59 against an hh+1:00 alarm.
    task automatic ring_from(input int d, input int h);
        do_set_time(d, h, 59, 0);
        do_tick(2);
        do_idle(1);
    endtask

    typedef struct {
        logic       tk;
        logic [2:0] d;
        logic [4:0] h;
        logic [5:0] m;
        logic [2:0] ed;
        logic [4:0] eh;
        logic [5:0] em;
    } tvec_t;

    tvec_t tv[7];

    initial begin
        int nt;
        tv[0] = '{0, 3, 12, 34, 3, 12, 34};
        tv[1] = '{0, 6, 23, 59, 6, 23, 59};
        tv[2] = '{0, 7, 10, 10, 6, 23, 59};
        tv[3] = '{0, 2, 24,  0, 6, 23, 59};
        tv[4] = '{0, 2, 10, 60, 6, 23, 59};
        tv[5] = '{0, 0,  0,  0, 0,  0,  0};
        tv[6] = '{1, 5, 23,  0, 5, 23,  0};

        // reset
        rst_n = 0; tick = 0; set_time = 0; set_alarm = 0; arm = 0; snooze = 0; stop = 0;
        set_day = 0; set_hr = 0; set_min = 0; alm_hr = 0; alm_min = 0; alm_days = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alrm", alrm, 0);
        check("rst_state", state, 0);
        check("rst_day", cur_day, 0);
        check("rst_hr", cur_hr, 0);
        check("rst_min", cur_min, 0);
        check("rst_snzcnt", snooze_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();

        // table of time loads, including rejected out-of-range values
        for (int i = 0; i < 7; i++) begin
            do_set_time(tv[i].d, tv[i].h, tv[i].m, tv[i].tk);
            check($sformatf("tbl%0d_day", i), cur_day, tv[i].ed);
            check($sformatf("tbl%0d_hr", i), cur_hr, tv[i].eh);
            check($sformatf("tbl%0d_min", i), cur_min, tv[i].em);
        end

        // time wrap at end of Saturday
        do_set_time(6, 23, 59, 0);
        do_tick(1);
        check("wrap_min_hold", cur_min, 59);
        do_tick(1);
        check("wrap_day", cur_day, 0);
        check("wrap_hr", cur_hr, 0);
        check("wrap_min", cur_min, 0);
        do_idle(1);
        check("wrap_noalrm", alrm, 0);

        // weekday trigger
        arm = 1;
        do_set_alarm(7, 0, 7'b0111110);
        do_set_time(1, 6, 59, 0);
        do_tick(2);
        check("wk_hr", cur_hr, 7);
        check("wk_min", cur_min, 0);
        check("wk_alrm_lat", alrm, 0);
        do_idle(1);
        check("wk_alrm", alrm, 1);
        check("wk_state", state, 1);
        stop = 1; clk_step();
        check("wk_stop_alrm", alrm, 0);
        check("wk_stop_state", state, 0);
        ring_from(0, 6);
        check("sun_noalrm", alrm, 0);
        check("sun_state", state, 0);

        // snooze, re-ring, exhausted snooze, stop
        ring_from(1, 6);
        check("snz_ring", alrm, 1);
        snooze = 1; clk_step();
        check("snz_state", state, 2);
        check("snz_cnt", snooze_cnt, 1);
        check("snz_alrm", alrm, 0);
        do_tick(4);
        check("snz_hold", state, 2);
        do_idle(1);
        check("snz_rering", state, 1);
        check("snz_rering_alrm", alrm, 1);
        snooze = 1; clk_step();
        check("snz_ignored", state, 1);
        check("snz_ignored_alrm", alrm, 1);
        check("snz_ignored_cnt", snooze_cnt, 1);
        stop = 1; clk_step();
        check("snz_stop", state, 0);
        check("snz_stop_cnt", snooze_cnt, 0);

        // ring timeout
        ring_from(1, 6);
        check("to_ring", state, 1);
        do_tick(2);
        do_idle(1);
        check("to_first_min", state, 1);
        do_tick(2);
        do_idle(1);
        check("to_idle", state, 0);
        check("to_alrm", alrm, 0);

        // set_time vs tick, out-of-range set_time
        do_set_time(2, 10, 10, 0);
        do_tick(1);
        do_set_time(2, 10, 10, 1);
        check("st_tick_min", cur_min, 10);
        do_tick(1);
        check("st_sec_cleared", cur_min, 10);
        do_tick(1);
        check("st_next_min", cur_min, 11);
        do_set_time(2, 24, 0, 0);
        check("st_hr24_hr", cur_hr, 10);
        check("st_hr24_min", cur_min, 11);

        // set_alarm while ringing, arm low while snoozed
        ring_from(1, 6);
        check("sa_ring", state, 1);
        do_set_alarm(8, 0, 7'h7f);
        check("sa_idle", state, 0);
        check("sa_alrm", alrm, 0);
        ring_from(3, 7);
        snooze = 1; clk_step();
        check("arm_snz", state, 2);
        arm = 0; clk_step();
        check("arm_idle", state, 0);
        check("arm_cnt", snooze_cnt, 0);
        arm = 1;

        // async reset while ringing
        ring_from(3, 7);
        check("ar_ring", alrm, 1);
        #2;
        rst_n = 0;
        #1;
        check("ar_alrm", alrm, 0);
        check("ar_state", state, 0);
        check("ar_day", cur_day, 0);
        check("ar_hr", cur_hr, 0);
        check("ar_min", cur_min, 0);
        check("ar_cnt", snooze_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick = ($urandom_range(0, 1) == 1);
            set_time = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                set_day = 3'd6; set_hr = 5'd23; set_min = 6'd59;
            end else begin
                set_day = 3'($urandom_range(0, 7));
                set_hr  = 5'($urandom_range(0, 25));
                set_min = 6'($urandom_range(0, 61));
            end
            set_alarm = ($urandom_range(0, 149) == 0);
            nt = (m_t + $urandom_range(0, 2)) % 10080;
            alm_hr   = 5'((nt / 60) % 24);
            alm_min  = 6'(nt % 60);
            if ($urandom_range(0, 7) == 0) alm_hr = 5'($urandom_range(24, 31));
            alm_days = 7'($urandom_range(0, 127));
            if (arm) arm = ($urandom_range(0, 299) != 0);
            else     arm = ($urandom_range(0, 9) == 0);
            snooze = ($urandom_range(0, 24) == 0);
            stop   = ($urandom_range(0, 59) == 0);
            clk_step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alarm_sched.md
# alarm_sched

Sequential, parametrised successor to the combinational weekday alarm decoder. Keeps day-of-week / hour / minute time from a 1 Hz tick strobe. Raises `alrm` when the programmed alarm time is reached on an enabled day, and manages ringing, snooze and timeout with a three-state FSM. Sits between the timebase divider and the buzzer/UI logic of the clock design.

## Interface
Parameters:
- TICKS_PER_MIN, 60, tick strobes per minute (≥2)
- SNOOZE_MIN, 9, minutes from snooze to re-ring (≥1)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (≥0)
- RING_MIN, 5, minute boundaries spent ringing before auto-stop (≥1)
- DEFAULT_DAYS, 7'b0111110, reset day mask; bit d enables day d (0 = Sunday)

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- tick  in  1  one-cycle 1 Hz strobe
- set_time  in  1  load the set_* time fields
- set_day / set_hr / set_min  in  3/5/6  time load value
- set_alarm  in  1  load the alm_* fields
- alm_hr / alm_min / alm_days  in  5/6/7  alarm time and day mask
- arm  in  1  level; alarm enabled while high
- snooze  in  1  one-cycle request
- stop  in  1  one-cycle request
- alrm  out  1  high while RINGING
- cur_day / cur_hr / cur_min  out  3/5/6  current time
- state  out  2  00 IDLE, 01 RINGING, 10 SNOOZED
- snooze_cnt  out  clog2(MAX_SNOOZE+1)  snoozes used in the current event

## Operation
- Reset values: cur_day, cur_hr and cur_min = 0; seconds counter = 0; alarm time = 00:00; day mask = DEFAULT_DAYS; state = IDLE; alrm = 0; snooze_cnt = 0; internal min_upd = 0.
- Timekeeping: each tick increments sec (0..TICKS_PER_MIN-1). When sec wraps, cur_min increments. 59→0 carries into cur_hr, 23→0 carries into cur_day, and 6 wraps to 0. Any wrap of sec sets the registered pulse min_upd for exactly one cycle.
- set_time loads day, hour and minute, clears sec, and does not set min_upd. If set_time and tick fall in the same cycle, set_time wins and the tick is dropped. Out-of-range loads (day>6, hr>23, min>59) are ignored entirely.
- set_alarm loads alm_hr, alm_min and alm_days, with the same range check. An accepted set_alarm in RINGING or SNOOZED forces IDLE and clears snooze_cnt.
- match = min_upd & arm & (cur_hr==alm_hr) & (cur_min==alm_min) & alm_days[cur_day].
- FSM:
  - IDLE → RINGING on match. ring_cnt is cleared.
  - RINGING:
    - stop → IDLE, snooze_cnt cleared.
    - Else snooze with snooze_cnt < MAX_SNOOZE → SNOOZED, snooze_cnt+1, snz_cnt loaded with SNOOZE_MIN.
    - Snooze with snooze_cnt == MAX_SNOOZE is ignored.
    - Else each min_upd increments ring_cnt. On reaching RING_MIN → IDLE, snooze_cnt cleared.
  - SNOOZED:
    - stop → IDLE, snooze_cnt cleared.
    - Each min_upd decrements snz_cnt. The decrement to 0 → RINGING with ring_cnt cleared.
  - arm low in any state forces IDLE next edge and clears snooze_cnt.
  - Priority: reset > set_alarm > arm low > stop > snooze > timer events.
- Timer widths: clog2(max(SNOOZE_MIN, RING_MIN)+1). All counters saturate or clear as above and never wrap.

## Timing
- Edge E updates cur_min to the alarm time and sets min_upd. At edge E+1, state = RINGING and alrm = 1 (1-cycle latency). alrm is a registered decode of state.
- stop or snooze sampled at edge N: alrm is low after edge N.
- SNOOZED→RINGING occurs at the edge after the SNOOZE_MIN-th min_upd following snooze.
- Reset mid-ring: alrm drops asynchronously with rst_n low.

## Test plan
- Time wrap (TICKS_PER_MIN=2): set_time 6/23:59, 2 ticks → cur = 0/00:00, min_upd high for one cycle, alrm stays 0.
- Weekday trigger: alarm 07:00, mask 0111110, time 1/06:59, arm=1. Two ticks → alrm=1 exactly one cycle after cur_min=0. Same test with day 0 → alrm stays 0.
- Snooze (SNOOZE_MIN=2, MAX_SNOOZE=1): ring, then snooze → state=10, snooze_cnt=1. After 2 minute rollovers → RINGING. A second snooze is ignored, alrm stays 1, and stop → IDLE with snooze_cnt=0.
- Timeout (RING_MIN=2): ring with no input → IDLE after 2nd minute rollover; no re-trigger at 07:01.
- Conflicts: set_time with tick in the same cycle → sec=0 and the loaded time is held. set_time hr=24 → ignored. set_alarm while RINGING → IDLE. arm low while SNOOZED → IDLE.
- Async reset asserted during RINGING → every output is at its reset value immediately, with no clock edge required.
